visited_arbiter: RTL and testbench

- Shares one checked/visited status RAM among NUM_REQ traversal processors.
- Status RAM: 2 bits per vertex, bit1 = checked, bit0 = visited; 2-cycle registered read.
- Per-cycle round-robin arbitration for READ, WRITE and atomic TEST_SET (read old value, OR in new bits).
- Also runs a clear sweep that zeroes the whole RAM before each traversal.
- Sits between the processor array and the status RAM instance; drives that RAM's address, data and write-enable pins.

---
 rtl/visited_arbiter_pkg.sv | 26 ++
 rtl/visited_arbiter_if.sv | 23 ++
 rtl/visited_arbiter_rr_arbiter.sv | 30 +++
 rtl/visited_arbiter.sv | 177 +++++++++++++++++
 tb/tb_visited_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/visited_arbiter_pkg.sv
// Shared types and constants for the visited-status RAM arbiter.
// Status entries are 2 bits: bit1 = checked, bit0 = visited.
package visited_arb_pkg;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_TEST_SET = 2'd2
    } op_e;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        TAS_WAIT = 2'd1,
        TAS_WR   = 2'd2,
        CLEAR    = 2'd3
    } state_e;

    localparam int CHECKED_BIT = 1;
    localparam int VISITED_BIT = 0;

    // TEST_SET write-back: status bits only ever get set, never cleared
    function automatic logic [1:0] tas_merge(input logic [1:0] old_val, input logic [1:0] mask);
        return old_val | mask;
    endfunction

endpackage

// File: rtl/visited_arbiter_if.sv
// Requester-side bundle: per-requester request lanes plus the shared response bus.
interface visited_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 10
);
    logic [NUM_REQ-1:0]                 req_valid_in;
    logic [NUM_REQ-1:0][1:0]            req_op_in;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr_in;
    logic [NUM_REQ-1:0][1:0]            req_data_in;
    logic [NUM_REQ-1:0]                 req_ready_out;
    logic [NUM_REQ-1:0]                 rsp_valid_out;
    logic [1:0]                         rsp_data_out;

    modport master (
        output req_valid_in, req_op_in, req_addr_in, req_data_in,
        input  req_ready_out, rsp_valid_out, rsp_data_out
    );

    modport slave (
        input  req_valid_in, req_op_in, req_addr_in, req_data_in,
        output req_ready_out, rsp_valid_out, rsp_data_out
    );
endinterface

// File: rtl/visited_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (!any_o && en_i && req_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = IDX_W'(j);
                any_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/visited_arbiter.sv
// Shares one checked/visited status RAM among NUM_REQ traversal processors:
// round-robin READ/WRITE/TEST_SET plus a full-RAM clear sweep.
module visited_arbiter
    import visited_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 10,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    visited_arbiter_if.slave      req_if,
    input  logic                  clear_start_in,
    output logic                  clear_busy_out,
    output logic                  clear_done_out,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [1:0]            bram_din_out,
    output logic                  bram_we_out,
    input  logic [1:0]            bram_dout_in
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // One bit wider than the address so DEPTH = 2^ADDR_WIDTH still terminates
    localparam int CNT_W = ADDR_WIDTH + 1;

    state_e                           state_q, state_d;
    logic [IDX_W-1:0]                 ptr_q, ptr_d;
    logic [CNT_W-1:0]                 cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]            tas_addr_q, tas_addr_d;
    logic [1:0]                       tas_mask_q, tas_mask_d;
    logic                             pend_q, pend_d;
    logic                             done_q, done_d;
    logic [READ_LATENCY:1]            vld_pipe_q;
    logic [READ_LATENCY:1][IDX_W-1:0] id_pipe_q;

    logic                  arb_en, gany, push;
    logic [NUM_REQ-1:0]    gnt;
    logic [IDX_W-1:0]      gidx;
    op_e                   g_op;
    logic [ADDR_WIDTH-1:0] g_addr;
    logic [1:0]            g_data;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [1:0]            bram_din;
    logic                  bram_we;
    logic [NUM_REQ-1:0]    rsp_valid;

    // A pending or fresh clear takes priority over every request this cycle
    assign arb_en = (state_q == ARB) && !clear_start_in && !pend_q && !rst_in;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req_i (req_if.req_valid_in),
        .ptr_i (ptr_q),
        .en_i  (arb_en),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    assign g_op   = op_e'(req_if.req_op_in[gidx]);
    assign g_addr = req_if.req_addr_in[gidx];
    assign g_data = req_if.req_data_in[gidx];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tas_addr_d = tas_addr_q;
        tas_mask_d = tas_mask_q;
        pend_d     = pend_q;
        done_d     = 1'b0;
        push       = 1'b0;
        bram_addr  = '0;
        bram_din   = '0;
        bram_we    = 1'b0;
        case (state_q)
            ARB: begin
                if (clear_start_in || pend_q) begin
                    state_d = CLEAR;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end else if (gany) begin
                    ptr_d     = (gidx == IDX_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                    bram_addr = g_addr;
                    case (g_op)
                        OP_WRITE: begin
                            bram_din = g_data;
                            bram_we  = 1'b1;
                        end
                        OP_TEST_SET: begin
                            push       = 1'b1;
                            tas_addr_d = g_addr;
                            tas_mask_d = g_data;
                            cnt_d      = '0;
                            state_d    = TAS_WAIT;
                        end
                        default: push = 1'b1;
                    endcase
                end
            end
            TAS_WAIT: begin
                pend_d = pend_q | clear_start_in;
                if (cnt_q == CNT_W'(READ_LATENCY - 2)) state_d = TAS_WR;
                else                                   cnt_d   = cnt_q + 1'b1;
            end
            TAS_WR: begin
                // Old value is on the RAM output now; its response leaves via the tag pipe
                bram_addr = tas_addr_q;
                bram_din  = tas_merge(bram_dout_in, tas_mask_q);
                bram_we   = 1'b1;
                if (pend_q || clear_start_in) begin
                    state_d = CLEAR;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = ARB;
                end
            end
            CLEAR: begin
                bram_addr = cnt_q[ADDR_WIDTH-1:0];
                bram_we   = 1'b1;
                if (cnt_q == CNT_W'(DEPTH - 1)) begin
                    state_d = ARB;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ARB;
            ptr_q      <= '0;
            cnt_q      <= '0;
            tas_addr_q <= '0;
            tas_mask_q <= '0;
            pend_q     <= 1'b0;
            done_q     <= 1'b0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tas_addr_q <= tas_addr_d;
            tas_mask_q <= tas_mask_d;
            pend_q     <= pend_d;
            done_q     <= done_d;
            // Tag pipe advances in every state so pre-clear reads still return
            vld_pipe_q[1] <= push;
            id_pipe_q[1]  <= gidx;
            for (int k = 2; k <= READ_LATENCY; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                id_pipe_q[k]  <= id_pipe_q[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (vld_pipe_q[READ_LATENCY]) rsp_valid[id_pipe_q[READ_LATENCY]] = 1'b1;
    end

    assign req_if.req_ready_out = gnt;
    assign req_if.rsp_valid_out = rsp_valid;
    assign req_if.rsp_data_out  = vld_pipe_q[READ_LATENCY] ? bram_dout_in : 2'b00;
    assign clear_busy_out       = (state_q == CLEAR);
    assign clear_done_out       = done_q;
    assign bram_addr_out        = bram_addr;
    assign bram_din_out         = bram_din;
    assign bram_we_out          = bram_we;

endmodule

// File: tb/tb_visited_arbiter.sv
// Bench for visited_arbiter: directed scenarios then random traffic, all checked
// cycle by cycle against a transaction-level model with a golden status memory.
module tb_visited_arbiter;
    import visited_arb_pkg::*;

    localparam int N     = 4;
    localparam int AW    = 10;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cs  = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         v  = '0;
    logic [N-1:0][1:0]    op = '0;
    logic [N-1:0][1:0]    wd = '0;
    logic [N-1:0][AW-1:0] ad = '0;
    logic                 busy, done, we;
    logic [AW-1:0]        baddr;
    logic [1:0]           bdin, bdout;

    visited_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW)) ifc ();
    assign ifc.req_valid_in = v;
    assign ifc.req_op_in    = op;
    assign ifc.req_addr_in  = ad;
    assign ifc.req_data_in  = wd;

    visited_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .req_if         (ifc),
        .clear_start_in (cs),
        .clear_busy_out (busy),
        .clear_done_out (done),
        .bram_addr_out  (baddr),
        .bram_din_out   (bdin),
        .bram_we_out    (we),
        .bram_dout_in   (bdout)
    );

    // Status RAM: read-first, two registered read stages
    logic [1:0] ram [DEPTH];
    logic [1:0] rd1 = 2'b00, rd2 = 2'b00;
    always @(posedge clk) begin
        rd1 <= ram[baddr];
        rd2 <= rd1;
        if (we) ram[baddr] <= bdin;
    end
    assign bdout = rd2;

    typedef struct { int due; int id; logic [1:0] d; } rsp_t;
    rsp_t       rq[$];
    logic [1:0] gm     [DEPTH];
    logic [1:0] gm_pre [DEPTH];
    int         cyc = 0, m_ptr = 0, m_stall = 0, m_clear = 0, tas_a = 0;
    bit         m_pend = 0, m_done = 0;
    logic [1:0] tas_old = 2'b00;
    logic [N-1:0] last_gnt = '0;
    int         nchk = 0, nerr = 0, done_cnt = 0, busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic start_clear();
        m_clear = DEPTH;
        m_pend  = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            gm_pre[a] = gm[a];
            gm[a]     = 2'b00;
        end
    endtask

    // Reference model: evaluated mid-cycle with the inputs of that cycle
    always @(negedge clk) begin
        int gi, j, a;
        logic [N-1:0] er, erv;
        logic [1:0]   erd;
        cyc++;
        last_gnt = ifc.req_ready_out;
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        if (rst) begin
            // Sweep reached address DEPTH-m_clear this cycle; the rest keeps old data
            if (m_clear > 0)
                for (int k = 0; k < DEPTH; k++) if (k > DEPTH - m_clear) gm[k] = gm_pre[k];
            if (m_stall > 1) gm[tas_a] = tas_old;
            m_ptr = 0; m_stall = 0; m_clear = 0; m_pend = 0; m_done = 0;
            rq.delete();
        end else begin
            chk("clear_busy", 32'(busy), 32'(m_clear > 0));
            chk("clear_done", 32'(done), 32'(m_done));
            gi = -1;
            if (m_clear == 0 && m_stall == 0 && !cs && !m_pend)
                for (int k = 0; k < N; k++) begin
                    j = (m_ptr + k) % N;
                    if (gi < 0 && v[j]) gi = j;
                end
            er = '0;
            if (gi >= 0) er[gi] = 1'b1;
            chk("req_ready", 32'(ifc.req_ready_out), 32'(er));
            erv = '0;
            erd = 2'b00;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv[rq[0].id] = 1'b1;
                erd = rq[0].d;
                void'(rq.pop_front());
            end
            chk("rsp_valid", 32'(ifc.rsp_valid_out), 32'(erv));
            if (erv != '0) chk("rsp_data", 32'(ifc.rsp_data_out), 32'(erd));

            if (m_clear > 0) begin
                m_clear--;
                m_done = (m_clear == 0);
            end else begin
                m_done = 1'b0;
                if (m_stall > 0) begin
                    if (cs) m_pend = 1'b1;
                    if (m_stall == 1 && m_pend) start_clear();
                    m_stall--;
                end else if (cs || m_pend) begin
                    start_clear();
                end else if (gi >= 0) begin
                    m_ptr = (gi + 1) % N;
                    a = int'(ad[gi]);
                    if (op[gi] == 2'd1) begin
                        gm[a] = wd[gi];
                    end else begin
                        rq.push_back(rsp_t'{cyc + LAT, gi, gm[a]});
                        if (op[gi] == 2'd2) begin
                            tas_a   = a;
                            tas_old = gm[a];
                            gm[a]   = gm[a] | wd[gi];
                            m_stall = LAT;
                        end
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Hold every raised request until it has been granted
    task automatic drain();
        int n = 0;
        while (v != '0 && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
            v = v & ~last_gnt;
        end
        if (v != '0) begin
            chk("drain_timeout", 32'(v), 32'd0);
            v = '0;
        end
    endtask

    task automatic issue(input int i, input int o, input int a, input int d);
        op[i] = 2'(o);
        ad[i] = AW'(a);
        wd[i] = 2'(d);
        v[i]  = 1'b1;
        drain();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dc;
        for (int a = 0; a < DEPTH; a++) begin
            ram[a] = 2'($urandom_range(0, 3));
            gm[a]  = ram[a];
        end
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Clear sweep; a WRITE raised during the sweep is never granted
        busy_cnt = 0;
        cs = 1'b1; tick(1); cs = 1'b0;
        op[0] = 2'd1; ad[0] = 10'd100; wd[0] = 2'd3; v[0] = 1'b1;
        tick(50);
        v[0] = 1'b0;
        tick(1000);
        chk("clear_done_pulses", 32'(done_cnt), 32'd1);
        chk("clear_busy_cycles", 32'(busy_cnt), 32'd1024);
        issue(0, 0, 5, 0);
        tick(3);

        // Round robin over four concurrent READs
        for (int i = 0; i < N; i++) begin
            op[i] = 2'd0; ad[i] = AW'(10 + i); wd[i] = 2'd0;
        end
        v = '1;
        drain();
        tick(3);

        // Back-to-back TEST_SET on one vertex
        issue(1, 2, 7, 1);
        issue(2, 2, 7, 2);
        tick(4);
        chk("ram7_after_tas", 32'(ram[7]), 32'd3);

        // WRITE then READ of the same address on the next cycle
        op[0] = 2'd1; ad[0] = 10'd20; wd[0] = 2'd3; v[0] = 1'b1;
        tick(1);
        v = v & ~last_gnt;
        op[1] = 2'd0; ad[1] = 10'd20; v[1] = 1'b1;
        drain();
        tick(3);

        // clear_start while a TEST_SET is waiting for its read data
        issue(3, 2, 7, 1);
        cs = 1'b1; tick(1); cs = 1'b0;
        tick(1030);
        issue(0, 0, 7, 0);
        tick(3);
        chk("ram7_after_clear", 32'(ram[7]), 32'd0);

        // Reset with a READ in flight drops its response
        issue(0, 0, 5, 0);
        rst = 1'b1; tick(1); rst = 1'b0;
        tick(3);

        // Reset in the middle of a sweep, with the pointer away from 0
        issue(1, 0, 3, 0);
        dc = done_cnt;
        cs = 1'b1; tick(1); cs = 1'b0;
        tick(300);
        rst = 1'b1; tick(1); rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rsp_valid", 32'(ifc.rsp_valid_out), 32'd0);
        chk("rst_bram_we", 32'(we), 32'd0);
        for (int i = 0; i < N; i++) begin
            op[i] = 2'd0; ad[i] = AW'(400 + i);
        end
        v = '1;
        drain();
        tick(1100);
        chk("no_done_after_reset", 32'(done_cnt), 32'(dc));

        // Random traffic on a small address window to provoke collisions
        repeat (4000) begin
            @(posedge clk);
            #1;
            v = v & ~last_gnt;
            for (int i = 0; i < N; i++)
                if (!v[i] && $urandom_range(0, 2) == 0) begin
                    op[i] = 2'($urandom_range(0, 3));
                    ad[i] = AW'($urandom_range(0, 15));
                    wd[i] = 2'($urandom_range(0, 3));
                    v[i]  = 1'b1;
                end
            cs = ($urandom_range(0, 999) == 0);
        end
        cs = 1'b0;
        drain();
        tick(1100);

        for (int a = 0; a < DEPTH; a++) chk("ram_final", 32'(ram[a]), 32'(gm[a]));

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
